// File: rtl/lab08_pio_in_edge_if.sv
// lab08_pio_in_edge_if: Avalon-MM slave register bus for the PIO input port
`timescale 1ns/1ps
interface lab08_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab08_pio_in_edge.sv
// lab08_pio_in_edge: Avalon-MM PIO input with synchronizer, edge capture and optional level IRQ (macro LAB08_PIO_IN_IRQ_EN)
`timescale 1ns/1ps
module lab08_pio_in_edge #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    lab08_pio_in_edge_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] sync_q, prev_q, ec_q, ec_d, edges, clr, mask_v;
    logic [2:0]       cnt_q;
    logic             primed_q, rd_en, wr_en;
    logic [31:0]      rdata_d;

    assign sync_q = chain_q[SYNC_STAGES-1];
    assign rd_en  = bus.chipselect && bus.write_n;
    assign wr_en  = bus.chipselect && !bus.write_n;

    // input synchronizer chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], in_port};
            prev_q  <= sync_q;
        end

    // hold off edge detection until the chain and prev hold real samples
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else if (!primed_q) begin
            cnt_q    <= cnt_q + 3'd1;
            primed_q <= cnt_q == 3'(SYNC_STAGES);
        end

    assign edges = !primed_q      ? '0 :
                   EDGE_TYPE == 0 ? sync_q & ~prev_q :
                   EDGE_TYPE == 1 ? ~sync_q & prev_q :
                                    sync_q ^ prev_q;
    assign clr  = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    assign ec_d = (ec_q & ~clr) | edges;

    // latched edges; a new edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ec_q <= '0;
        else          ec_q <= ec_d;

`ifdef LAB08_PIO_IN_IRQ_EN
    logic [WIDTH-1:0] mask_q;
    logic             irq_q;
    assign mask_v = mask_q;
    assign irq    = irq_q;

    // interrupt mask register and registered level interrupt
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && bus.address == 2'd2) mask_q <= bus.writedata[WIDTH-1:0];
            irq_q <= |(ec_q & mask_q);
        end
`else
    assign mask_v = '0;
    assign irq    = 1'b0;
`endif

    assign rdata_d = bus.address == 2'd0 ? 32'(sync_q) :
                     bus.address == 2'd2 ? 32'(mask_v) :
                     bus.address == 2'd3 ? 32'(ec_q)   : 32'h0;

    // registered read data, updated only on read cycles
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)   bus.readdata <= '0;
        else if (rd_en) bus.readdata <= rdata_d;
endmodule

// File: tb/tb_lab08_pio_in_edge.sv
// tb_lab08_pio_in_edge: checks three edge-type variants against a sample-history reference model
`timescale 1ns/1ps
module tb_lab08_pio_in_edge;
    localparam int S = 2;
`ifdef LAB08_PIO_IN_IRQ_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic        clk = 1'b0, reset_n = 1'b1;
    logic [1:0]  addr = '0;
    logic        cs = 1'b0, wn = 1'b1;
    logic [31:0] wd = '0;
    logic [7:0]  inp = '0;
    logic [31:0] rd_obs [3];
    logic        irq_obs [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        lab08_pio_in_edge_if b ();
        assign b.address    = addr;
        assign b.chipselect = cs;
        assign b.write_n    = wn;
        assign b.writedata  = wd;
        assign rd_obs[g]    = b.readdata;
        lab08_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(g), .SYNC_STAGES(S)) dut (
            .clk(clk), .reset_n(reset_n), .bus(b), .in_port(inp), .irq(irq_obs[g])
        );
    end

    logic [7:0]  samp [0:4095];
    int          n = 0;
    logic [7:0]  m_ec [3];
    logic [7:0]  m_mask;
    logic [31:0] m_rd [3];
    logic        m_irq [3];
    int          checks = 0, errors = 0;

    function automatic logic [7:0] sync_at(int k);
        return (k - S + 1 >= 1) ? samp[k - S + 1] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < 3; t++) begin
            m_ec[t] = '0; m_rd[t] = '0; m_irq[t] = 1'b0;
        end
        m_mask = '0;
        n = 0;
    endtask

    task automatic tick(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d, input logic [7:0] i);
        logic [7:0] s, p, e, clr;
        bit primed;
        addr = a; cs = c; wn = w; wd = d; inp = i;
        s = sync_at(n);
        p = sync_at(n - 1);
        primed = n >= S + 1;
        clr = (c && !w && a == 2'd3) ? d[7:0] : 8'h00;
        for (int t = 0; t < 3; t++) begin
            e = !primed ? 8'h00 : t == 0 ? s & ~p : t == 1 ? ~s & p : s ^ p;
            if (c && w) m_rd[t] = a == 2'd0 ? {24'h0, s} : (a == 2'd2 && EN) ? {24'h0, m_mask} : a == 2'd3 ? {24'h0, m_ec[t]} : 32'h0;
            m_irq[t] = EN && |(m_ec[t] & m_mask);
            m_ec[t] = (m_ec[t] & ~clr) | e;
        end
        if (EN && c && !w && a == 2'd2) m_mask = d[7:0];
        n++;
        samp[n] = i;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("rd%0d@%0d", t, n), rd_obs[t], m_rd[t]);
            chk($sformatf("irq%0d@%0d", t, n), {31'h0, irq_obs[t]}, {31'h0, m_irq[t]});
        end
    endtask

    task automatic do_reset(input logic [7:0] i);
        #2 reset_n = 1'b0;
        inp = i; cs = 1'b0; wn = 1'b1; addr = '0; wd = '0;
        #1;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("rst_rd%0d", t), rd_obs[t], 32'h0);
            chk($sformatf("rst_irq%0d", t), {31'h0, irq_obs[t]}, 32'h0);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        model_clear();
        do_reset(8'hFF);
        repeat (10) tick(2'd0, 1'b0, 1'b1, 32'h0, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("pwr_ec", rd_obs[0], 32'h0);
        tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("pwr_data", rd_obs[0], 32'hFF);
        chk("pwr_irq", {31'h0, irq_obs[0]}, 32'h0);
        tick(2'd2, 1'b1, 1'b0, 32'h08, 8'hF7);
        repeat (4) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hF7);
        tick(2'd3, 1'b1, 1'b0, 32'hFF, 8'hF7);
        tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        for (int j = 1; j <= S; j++) begin
            tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
            chk($sformatf("data_lat%0d", j), rd_obs[0], j == S ? 32'hFF : 32'hF7);
        end
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("ec_rise", rd_obs[0], 32'h08);
        chk("irq_rise", {31'h0, irq_obs[0]}, {31'h0, EN});
        repeat (S + 2) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFB);
        repeat (S + 2) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("ec_0c", rd_obs[0], 32'h0C);
        tick(2'd3, 1'b1, 1'b0, 32'h04, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("ec_after_clr4", rd_obs[0], 32'h08);
        chk("irq_hold", {31'h0, irq_obs[0]}, {31'h0, EN});
        tick(2'd3, 1'b1, 1'b0, 32'h08, 8'hFF);
        chk("irq_lag", {31'h0, irq_obs[0]}, {31'h0, EN});
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("irq_drop", {31'h0, irq_obs[0]}, 32'h0);
        chk("ec_empty", rd_obs[0], 32'h0);
        repeat (S + 2) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hDF);
        tick(2'd3, 1'b1, 1'b0, 32'hFF, 8'hDF);
        tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        repeat (S - 1) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        tick(2'd3, 1'b1, 1'b0, 32'h20, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("set_beats_clr", rd_obs[0], 32'h20);
        tick(2'd3, 1'b1, 1'b0, 32'hFF, 8'hFE);
        repeat (S + 1) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFE);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFE);
        chk("any_fall", rd_obs[2], 32'h01);
        chk("fall_fall", rd_obs[1], 32'h01);
        chk("rise_fall", rd_obs[0], 32'h0);
        tick(2'd3, 1'b1, 1'b0, 32'h01, 8'hFF);
        repeat (S + 1) tick(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("any_rise", rd_obs[2], 32'h01);
        chk("fall_rise", rd_obs[1], 32'h0);
        chk("rise_rise", rd_obs[0], 32'h01);
        tick(2'd2, 1'b1, 1'b0, 32'hFF, 8'hFF);
        tick(2'd0, 1'b0, 1'b0, 32'h0, 8'hFF);
        tick(2'd2, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("mask_rd", rd_obs[0], EN ? 32'hFF : 32'h0);
        chk("mask_irq", {31'h0, irq_obs[0]}, {31'h0, EN});
        tick(2'd1, 1'b1, 1'b0, 32'hFF, 8'hFF);
        tick(2'd1, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("reserved", rd_obs[0], 32'h0);
        tick(2'd3, 1'b0, 1'b0, 32'hFF, 8'hFF);
        tick(2'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("cs0_write", rd_obs[0], 32'h01);
        do_reset(8'h00);
        for (int a = 0; a < 4; a++) begin
            tick(2'(a), 1'b1, 1'b1, 32'h0, 8'h00);
            chk($sformatf("post_rst_a%0d", a), rd_obs[0], 32'h0);
        end
        v = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(v);
            if ($urandom_range(0, 3) == 0) v = v ^ 8'($urandom);
            tick(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom, v);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
